// File: rtl/rom_download_loader.sv
// rom_download_loader
//   Turns the data_io byte download stream into word-wide memory writes.
//   Bytes are packed into DW-bit words. Finished words are queued in a
//   small FIFO and handed to the memory controller over a toggle req/ack
//   handshake. The block also generates the game-core reset, which stays
//   high until the ROM image has reached memory, plus RESET_HOLD cycles.
// Ports
//   clk_sys, reset             system clock, synchronous active-high reset
//   ioctl_downl/index/wr/      data_io download stream (byte address/data)
//   addr/dout
//   user_reset                 OSD/button reset request
//   mem_req/mem_ack            toggle handshake to the memory controller
//   mem_addr/din/ds/we         write word address, data, byte enables, write flag
//   busy, rom_loaded           load status
//   core_reset                 reset to the game core
//   overflow                   sticky: a word was dropped because the FIFO was full
module rom_download_loader #(
  parameter int DW         = 16,
  parameter int AW         = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX      = 0,
  parameter int RESET_HOLD = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          user_reset,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic [DW/8-1:0] mem_ds,
  output logic          mem_we,
  output logic          busy,
  output logic          rom_loaded,
  output logic          core_reset,
  output logic          overflow
);
  localparam int NB = DW / 8;
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int LW = (LB > 0) ? LB : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = AW + DW + NB;
  localparam int CW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOADING, S_DRAIN, S_HOLD, S_RUN} state_t;

  // Input edge detection
  logic wr_d_reg, downl_d_reg;
  logic idx_ok, acc, dl_rise, dl_fall;
  assign idx_ok  = (ioctl_index == 8'(INDEX));
  assign acc     = ioctl_downl & idx_ok & ioctl_wr & ~wr_d_reg;
  assign dl_rise = ioctl_downl & ~downl_d_reg & idx_ok;
  assign dl_fall = ~ioctl_downl & downl_d_reg;

  // Byte lane and word address of the incoming byte
  logic [LW-1:0] lane;
  logic [AW-1:0] waddr;
  assign lane  = (NB > 1) ? ioctl_addr[LW-1:0] : '0;
  assign waddr = ioctl_addr[AW+LB-1:LB];

  generate
    if (AW + LB < 25) begin : g_unused
      logic unused_addr;
      assign unused_addr = &{1'b0, ioctl_addr[24:AW+LB]};
    end
  endgenerate

  // Packer
  logic [AW-1:0] pa_reg;
  logic [DW-1:0] pd_reg, pd_next;
  logic [NB-1:0] pe_reg, pe_next;
  logic          full_reg;
  logic          new_word, push;

  assign new_word = (pe_reg == '0) || (waddr != pa_reg);

  // Per-lane merge: a new word starts from blank lanes, otherwise the
  // incoming byte replaces just its own lane.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic hit;
      assign hit = (lane == LW'(gi));
      assign pd_next[8*gi +: 8] = hit ? ioctl_dout : (new_word ? 8'h00 : pd_reg[8*gi +: 8]);
      assign pe_next[gi]        = hit | (~new_word & pe_reg[gi]);
    end
  endgenerate

  // full_reg pushes one cycle after the last lane lands; an address change
  // flushes the old word before the new byte replaces it; download end
  // flushes a partial word. acc can never coincide with full_reg because a
  // strobe needs ioctl_wr low for a cycle before it can rise again.
  assign push = full_reg | (((acc & (waddr != pa_reg)) | dl_fall) & (pe_reg != '0));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_d_reg    <= 1'b0;
      downl_d_reg <= 1'b0;
      pa_reg      <= '0;
      pd_reg      <= '0;
      pe_reg      <= '0;
      full_reg    <= 1'b0;
    end else begin
      wr_d_reg    <= ioctl_wr;
      downl_d_reg <= ioctl_downl;
      if (full_reg || dl_fall) begin
        pe_reg   <= '0;
        full_reg <= 1'b0;
      end
      if (acc) begin
        pa_reg   <= waddr;
        pd_reg   <= pd_next;
        pe_reg   <= pe_next;
        full_reg <= (lane == LW'(NB - 1));
      end
    end
  end

  // Pending-write FIFO (pointers carry one wrap bit)
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          fifo_empty, fifo_full, issue;
  logic          req_reg, we_reg, ovf_reg, port_idle;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                      (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign port_idle  = (req_reg == mem_ack);
  // we_reg is still high in the cycle the ack is seen, which pushes the
  // next issue to the following cycle.
  assign issue      = port_idle & ~we_reg & ~fifo_empty;

  always_ff @(posedge clk_sys) begin
    if (push && !fifo_full)
      fifo_mem[wr_ptr_reg[PW-1:0]] <= {pa_reg, pd_reg, pe_reg};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      req_reg    <= mem_ack;
      we_reg     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_ds     <= '0;
    end else begin
      if (push && !fifo_full) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (dl_rise) ovf_reg <= 1'b0;
      else if (push && fifo_full) ovf_reg <= 1'b1;
      if (issue) begin
        {mem_addr, mem_din, mem_ds} <= fifo_mem[rd_ptr_reg[PW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
        req_reg    <= ~req_reg;
        we_reg     <= 1'b1;
      end else if (we_reg && port_idle) begin
        we_reg <= 1'b0;
      end
    end
  end

  // Load state machine
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          loaded_reg, loaded_next;
  logic          core_reset_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      loaded_reg     <= 1'b0;
      core_reset_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      loaded_reg     <= loaded_next;
      // Uses the next state so the fall lands on the cycle RUN is entered.
      core_reset_reg <= user_reset | (state_next != S_RUN);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    loaded_next = loaded_reg;
    if (dl_rise) begin
      state_next  = S_LOADING;
      loaded_next = 1'b0;
    end else begin
      case (state_reg)
        S_LOADING: if (dl_fall) state_next = S_DRAIN;
        S_DRAIN: begin
          if (fifo_empty && (pe_reg == '0) && !full_reg && port_idle) begin
            state_next  = S_HOLD;
            loaded_next = 1'b1;
            cnt_next    = CW'(RESET_HOLD);
          end
        end
        S_HOLD: begin
          if (cnt_reg == '0) state_next = S_RUN;
          else cnt_next = cnt_reg - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = req_reg;
  assign mem_we     = we_reg;
  assign overflow   = ovf_reg;
  assign rom_loaded = loaded_reg;
  assign core_reset = core_reset_reg;
  assign busy       = (state_reg == S_LOADING) || (state_reg == S_DRAIN);
endmodule

// File: tb/tb_rom_download_loader.sv
// tb_rom_download_loader
//   Directed bench. dut16 (DW=16) has a bench-driven auto-ack memory port
//   whose writes are logged; dut32 (DW=32) shares the download stream but
//   its ack is held still, so its FIFO fills up for the overflow case.
module tb_rom_download_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, downl, wr, user_reset;
  logic [7:0]  index, dout;
  logic [24:0] addr;
  logic        ack16, ack32;

  logic        req16, we16, busy16, loaded16, creset16, ovf16;
  logic [21:0] addr16;
  logic [15:0] din16;
  logic [1:0]  ds16;
  logic        req32, we32, busy32, loaded32, creset32, ovf32;
  logic [21:0] addr32;
  logic [31:0] din32;
  logic [3:0]  ds32;

  rom_download_loader #(.DW(16), .RESET_HOLD(16)) dut16 (
    .clk_sys(clk), .reset(reset), .ioctl_downl(downl), .ioctl_index(index),
    .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(user_reset),
    .mem_req(req16), .mem_ack(ack16), .mem_addr(addr16), .mem_din(din16),
    .mem_ds(ds16), .mem_we(we16), .busy(busy16), .rom_loaded(loaded16),
    .core_reset(creset16), .overflow(ovf16));

  rom_download_loader #(.DW(32)) dut32 (
    .clk_sys(clk), .reset(reset), .ioctl_downl(downl), .ioctl_index(index),
    .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(user_reset),
    .mem_req(req32), .mem_ack(ack32), .mem_addr(addr32), .mem_din(din32),
    .mem_ds(ds32), .mem_we(we32), .busy(busy32), .rom_loaded(loaded32),
    .core_reset(creset32), .overflow(ovf32));

  int n_cmp = 0;
  int n_fail = 0;
  int nw = 0;
  int n0;
  int k;
  logic [21:0] w_addr [64];
  logic [15:0] w_din  [64];
  logic [1:0]  w_ds   [64];
  logic        last_req16;
  bit          auto_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1ns after the edge, logs new write requests and
  // acknowledges them on the next edge when auto_ack is set.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset && req16 !== last_req16) begin
      if (nw < 64) begin
        w_addr[nw] = addr16;
        w_din[nw]  = din16;
        w_ds[nw]   = ds16;
      end
      $display("write %0d: addr=%0h din=%0h ds=%b", nw, addr16, din16, ds16);
      nw++;
      last_req16 = req16;
    end
    if (auto_ack && !reset) ack16 = req16;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    addr = a;
    dout = d;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
    tick();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && creset16; i++) tick();
    check("wait_run", creset16, 1'b0);
  endtask

  initial begin
    reset = 1'b1; downl = 1'b0; wr = 1'b0; user_reset = 1'b0;
    index = 8'd0; addr = '0; dout = 8'h00;
    ack16 = 1'b0; ack32 = 1'b0; auto_ack = 1'b1; last_req16 = 1'b0;
    ticks(3);
    check("rst_req", req16, ack16);
    check("rst_addr", addr16, 0);
    check("rst_din", din16, 0);
    check("rst_ds", ds16, 0);
    check("rst_we", we16, 0);
    check("rst_busy", busy16, 0);
    check("rst_loaded", loaded16, 0);
    check("rst_core_reset", creset16, 1);
    check("rst_overflow", ovf16, 0);
    last_req16 = req16;
    reset = 1'b0;
    tick();
    check("idle_core_reset", creset16, 1);

    // Foreign index is ignored completely
    index = 8'd1; downl = 1'b1; tick();
    send_byte(25'd0, 8'h01); send_byte(25'd1, 8'h02);
    send_byte(25'd2, 8'h03); send_byte(25'd3, 8'h04);
    downl = 1'b0; ticks(4);
    check("idx_no_write", nw, 0);
    check("idx_loaded", loaded16, 0);
    check("idx_busy", busy16, 0);
    index = 8'd0;

    // Two bytes make one 16-bit write, two cycles after the second strobe
    downl = 1'b1; tick();
    check("load_busy", busy16, 1);
    send_byte(25'd0, 8'h11);
    addr = 25'd1; dout = 8'h22; wr = 1'b1; tick();
    wr = 1'b0; tick();
    check("lat_not_yet", nw, 0);
    tick();
    check("lat_toggle", nw, 1);
    check("w0_addr", w_addr[0], 22'd0);
    check("w0_din", w_din[0], 16'h2211);
    check("w0_ds", w_ds[0], 2'b11);
    check("w0_we", we16, 1);

    // Third byte forms a partial word flushed at download end
    send_byte(25'd2, 8'h33);
    check("partial_held", nw, 1);
    downl = 1'b0; tick();
    check("fall_push_only", nw, 1);
    tick();
    check("partial_write", nw, 2);
    check("w1_addr", w_addr[1], 22'd1);
    check("w1_ds", w_ds[1], 2'b01);
    check("w1_din_lo", w_din[1][7:0], 8'h33);

    // Reset hold: core_reset falls 17 cycles after rom_loaded
    for (int i = 0; i < 50 && !loaded16; i++) tick();
    check("loaded", loaded16, 1);
    check("hold_core_reset", creset16, 1);
    check("hold_busy", busy16, 0);
    for (k = 0; k < 60 && creset16; k++) tick();
    check("hold_len", k, 17);

    // New download re-asserts core_reset next cycle; lane overwrite and
    // address jump inside the same download
    downl = 1'b1; tick();
    check("restart_core_reset", creset16, 1);
    check("restart_loaded", loaded16, 0);
    send_byte(25'd4, 8'hAA);
    send_byte(25'd4, 8'hBB);
    send_byte(25'd5, 8'hCC);
    send_byte(25'd6, 8'h44);
    send_byte(25'd10, 8'h55);
    downl = 1'b0; ticks(6);
    check("jump_count", nw, 5);
    check("w2_addr", w_addr[2], 22'd2);
    check("w2_din", w_din[2], 16'hCCBB);
    check("w2_ds", w_ds[2], 2'b11);
    check("w3_addr", w_addr[3], 22'd3);
    check("w3_ds", w_ds[3], 2'b01);
    check("w3_din_lo", w_din[3][7:0], 8'h44);
    check("w4_addr", w_addr[4], 22'd5);
    check("w4_ds", w_ds[4], 2'b01);
    check("w4_din_lo", w_din[4][7:0], 8'h55);
    wait_run();

    user_reset = 1'b1; tick();
    check("user_reset_on", creset16, 1);
    user_reset = 1'b0; tick();
    check("user_reset_off", creset16, 0);

    // Reset while a request is outstanding
    auto_ack = 1'b0;
    downl = 1'b1; tick();
    send_byte(25'd0, 8'h66);
    send_byte(25'd1, 8'h77);
    tick();
    check("outstanding", req16 ^ ack16, 1);
    check("outstanding_we", we16, 1);
    reset = 1'b1; downl = 1'b0;
    ticks(2);
    check("mid_rst_req", req16, ack16);
    check("mid_rst_we", we16, 0);
    check("mid_rst_core_reset", creset16, 1);
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_loaded", loaded16, 0);
    reset = 1'b0;
    last_req16 = req16;
    auto_ack = 1'b1;
    n0 = nw;
    ticks(10);
    check("no_write_after_reset", nw, n0);

    // Overflow on dut32 (ack never returns); dut16 drains normally
    downl = 1'b1; tick();
    check("ovf_clear", ovf32, 0);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i));
    check("ovf_not_yet", ovf32, 0);
    for (int i = 16; i < 32; i++) send_byte(25'(i), 8'(i));
    check("ovf_set", ovf32, 1);
    downl = 1'b0; ticks(6);
    check("ovf_sticky", ovf32, 1);
    check("ovf16_clear", ovf16, 0);
    check("drain16_count", nw, n0 + 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
